// File: rtl/rf_writeback_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module  : rf_writeback_arbiter_if
// Purpose : Bundles the two writeback producers and the register-file write
//           port of rf_writeback_arbiter.
// Rev     : 1.0  initial release
// ============================================================================
interface rf_writeback_arbiter_if #(
    parameter int NUM_REGS = 16,
    parameter int ADDR_W   = 4,
    parameter int DATA_W   = 64,
    parameter int DEPTH    = 2
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic                a_valid;
    logic                a_ready;
    logic [ADDR_W-1:0]   a_addr;
    logic [DATA_W-1:0]   a_data;
    logic                b_valid;
    logic                b_ready;
    logic [ADDR_W-1:0]   b_addr;
    logic [DATA_W-1:0]   b_data;
    logic                write_en;
    logic [ADDR_W-1:0]   waddr;
    logic [DATA_W-1:0]   wdata;
    logic [NUM_REGS-1:0] pending_mask;
    logic [CNT_W-1:0]    a_count;
    logic [CNT_W-1:0]    b_count;

    modport master (
        output a_valid, a_addr, a_data, b_valid, b_addr, b_data,
        input  a_ready, b_ready, write_en, waddr, wdata, pending_mask, a_count, b_count
    );

    modport slave (
        input  a_valid, a_addr, a_data, b_valid, b_addr, b_data,
        output a_ready, b_ready, write_en, waddr, wdata, pending_mask, a_count, b_count
    );
endinterface
`default_nettype wire

// File: rtl/rf_writeback_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : rf_writeback_arbiter
// Purpose : Two per-source in-order FIFOs, round-robin merged onto one
//           registered register-file write port, with a pending-write mask.
// Rev     : 1.0  initial release
// ============================================================================
module rf_writeback_arbiter #(
    parameter int NUM_REGS = 16,
    parameter int ADDR_W   = 4,
    parameter int DATA_W   = 64,
    parameter int DEPTH    = 2
) (
    input  wire logic              clk,
    input  wire logic              reset_n,
    rf_writeback_arbiter_if.slave  bus
);
    localparam int   PTR_W    = $clog2(DEPTH);
    localparam int   CNT_W    = PTR_W + 1;
    localparam logic c_SIDE_A = 1'b0;
    localparam logic c_SIDE_B = 1'b1;

    logic [ADDR_W-1:0] r_a_addr [DEPTH];
    logic [DATA_W-1:0] r_a_data [DEPTH];
    logic [ADDR_W-1:0] r_b_addr [DEPTH];
    logic [DATA_W-1:0] r_b_data [DEPTH];
    logic [PTR_W-1:0]  r_a_wr, r_a_rd, r_b_wr, r_b_rd;
    logic [CNT_W-1:0]  r_a_cnt, r_b_cnt;
    logic              r_rr_last;
    logic              r_we;
    logic [ADDR_W-1:0] r_waddr;
    logic [DATA_W-1:0] r_wdata;

    logic              w_a_ready, w_b_ready;
    logic              w_a_push, w_b_push;
    logic              w_a_ne, w_b_ne;
    logic              w_pop_a, w_pop_b;
    logic [ADDR_W-1:0] w_head_addr;
    logic [DATA_W-1:0] w_head_data;
    logic [NUM_REGS-1:0] w_pend;

    // Slot idx holds a live entry when its distance from the read pointer is below the count.
    function automatic logic slot_live(input logic [PTR_W-1:0] idx,
                                       input logic [PTR_W-1:0] rd,
                                       input logic [CNT_W-1:0] cnt);
        logic [PTR_W-1:0] off;
        off = idx - rd;
        return ({1'b0, off} < cnt);
    endfunction

    assign w_a_ready = (r_a_cnt != CNT_W'(DEPTH));
    assign w_b_ready = (r_b_cnt != CNT_W'(DEPTH));
    assign w_a_push  = bus.a_valid && w_a_ready;
    assign w_b_push  = bus.b_valid && w_b_ready;
    assign w_a_ne    = (r_a_cnt != '0);
    assign w_b_ne    = (r_b_cnt != '0);
    assign w_pop_a   = w_a_ne && (!w_b_ne || (r_rr_last == c_SIDE_B));
    assign w_pop_b   = w_b_ne && !w_pop_a;

    assign w_head_addr = w_pop_a ? r_a_addr[r_a_rd] : r_b_addr[r_b_rd];
    assign w_head_data = w_pop_a ? r_a_data[r_a_rd] : r_b_data[r_b_rd];

    // Entry storage is deliberately not reset; pointers and counts define validity.
    always_ff @(posedge clk) begin
        if (w_a_push) begin
            r_a_addr[r_a_wr] <= bus.a_addr;
            r_a_data[r_a_wr] <= bus.a_data;
        end
        if (w_b_push) begin
            r_b_addr[r_b_wr] <= bus.b_addr;
            r_b_data[r_b_wr] <= bus.b_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_a_wr    <= '0;
            r_a_rd    <= '0;
            r_a_cnt   <= '0;
            r_b_wr    <= '0;
            r_b_rd    <= '0;
            r_b_cnt   <= '0;
            r_rr_last <= c_SIDE_B;
            r_we      <= 1'b0;
            r_waddr   <= '0;
            r_wdata   <= '0;
        end else begin
            if (w_a_push) r_a_wr <= r_a_wr + PTR_W'(1);
            if (w_b_push) r_b_wr <= r_b_wr + PTR_W'(1);
            if (w_pop_a)  r_a_rd <= r_a_rd + PTR_W'(1);
            if (w_pop_b)  r_b_rd <= r_b_rd + PTR_W'(1);

            case ({w_a_push, w_pop_a})
                2'b10:   r_a_cnt <= r_a_cnt + CNT_W'(1);
                2'b01:   r_a_cnt <= r_a_cnt - CNT_W'(1);
                default: r_a_cnt <= r_a_cnt;
            endcase
            case ({w_b_push, w_pop_b})
                2'b10:   r_b_cnt <= r_b_cnt + CNT_W'(1);
                2'b01:   r_b_cnt <= r_b_cnt - CNT_W'(1);
                default: r_b_cnt <= r_b_cnt;
            endcase

            // Priority only rotates when both heads competed.
            if (w_a_ne && w_b_ne)
                r_rr_last <= w_pop_a ? c_SIDE_A : c_SIDE_B;

            r_we <= w_pop_a || w_pop_b;
            if (w_pop_a || w_pop_b) begin
                r_waddr <= w_head_addr;
                r_wdata <= w_head_data;
            end
        end
    end

    always_comb begin
        w_pend = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (slot_live(PTR_W'(i), r_a_rd, r_a_cnt)) w_pend[r_a_addr[i]] = 1'b1;
            if (slot_live(PTR_W'(i), r_b_rd, r_b_cnt)) w_pend[r_b_addr[i]] = 1'b1;
        end
        if (r_we) w_pend[r_waddr] = 1'b1;
    end

    assign bus.a_ready      = w_a_ready;
    assign bus.b_ready      = w_b_ready;
    assign bus.a_count      = r_a_cnt;
    assign bus.b_count      = r_b_cnt;
    assign bus.write_en     = r_we;
    assign bus.waddr        = r_waddr;
    assign bus.wdata        = r_wdata;
    assign bus.pending_mask = w_pend;
endmodule
`default_nettype wire
